uart_rx_drive: RTL and testbench

Bit-level UART receiver that turns the asynchronous serial input pin into byte strobes. It feeds `uart_rx_dma` (`i_rx_data`/`i_rx_valid`), which buffers bytes and releases them to the user after an idle gap. The block provides:
- input synchronisation and falling-edge start detection;
- mid-bit sampling;
- optional parity checking;
- stop-bit validation with framing/parity error strobes.

---
 rtl/uart_rx_drive.sv | 156 +++++++++++++++
 tb/tb_uart_rx_drive.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_drive.sv
// Bit-level UART receiver: synchronises the serial pin, samples each bit at mid-point,
// optionally checks parity and emits one data/error strobe per frame.
module uart_rx_drive #(
  parameter int P_CLK_FREQ = 50_000_000,
  parameter int P_BAUD     = 9600,
  parameter int P_CHECK    = 0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_uart_rx,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_frame_err,
  output logic       o_parity_err
);

  localparam int LP_DIV  = P_CLK_FREQ / P_BAUD;
  localparam int LP_HALF = LP_DIV / 2;
  localparam int CNT_W   = $clog2(LP_DIV);
  localparam logic [CNT_W-1:0] LP_SAMPLE = CNT_W'(LP_HALF - 1);
  localparam logic [CNT_W-1:0] LP_LAST   = CNT_W'(LP_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  function automatic logic parity_expected(input logic [7:0] d);
    return (P_CHECK == 1) ? ~^d : ^d;
  endfunction

  logic             r_rx_s1, r_rx_s2, r_rx_s3;
  state_t           r_state, state_nxt;
  logic [CNT_W-1:0] r_baud_cnt, cnt_nxt;
  logic [2:0]       r_bit_idx, idx_nxt;
  logic [7:0]       r_shift, shift_nxt;
  logic             r_par_err, par_err_nxt;
  logic [7:0]       data_nxt;
  logic             valid_nxt, frame_nxt, parity_nxt;
  logic             fall, sample, wrap;

  // Input synchroniser; idles high so reset never looks like a start edge
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_s3 <= 1'b1;
    end else begin
      r_rx_s1 <= i_uart_rx;
      r_rx_s2 <= r_rx_s1;
      r_rx_s3 <= r_rx_s2;
    end
  end

  assign fall   = r_rx_s3 & ~r_rx_s2;
  assign sample = (r_baud_cnt == LP_SAMPLE);
  assign wrap   = (r_baud_cnt == LP_LAST);

  always_comb begin
    state_nxt   = r_state;
    cnt_nxt     = wrap ? '0 : r_baud_cnt + CNT_W'(1);
    idx_nxt     = r_bit_idx;
    shift_nxt   = r_shift;
    par_err_nxt = r_par_err;
    data_nxt    = o_rx_data;
    valid_nxt   = 1'b0;
    frame_nxt   = 1'b0;
    parity_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        cnt_nxt     = '0;
        par_err_nxt = 1'b0;
        if (fall) state_nxt = S_START;
      end
      S_START: begin
        if (sample && r_rx_s2) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else if (wrap) begin
          state_nxt = S_DATA;
          idx_nxt   = 3'd0;
        end
      end
      S_DATA: begin
        if (sample) shift_nxt = {r_rx_s2, r_shift[7:1]};
        if (wrap) begin
          if (r_bit_idx == 3'd7) begin
            idx_nxt   = 3'd0;
            state_nxt = (P_CHECK != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_nxt = r_bit_idx + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (sample) par_err_nxt = (r_rx_s2 != parity_expected(r_shift));
        if (wrap) state_nxt = S_STOP;
      end
      S_STOP: begin
        // Leaving at mid-stop leaves half a bit to catch a back-to-back start edge
        if (sample) begin
          cnt_nxt = '0;
          if (r_rx_s2) begin
            state_nxt = S_IDLE;
            if (r_par_err) begin
              parity_nxt = 1'b1;
            end else begin
              data_nxt  = r_shift;
              valid_nxt = 1'b1;
            end
          end else begin
            frame_nxt = 1'b1;
            state_nxt = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        cnt_nxt = '0;
        if (r_rx_s2) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_baud_cnt   <= '0;
      r_bit_idx    <= 3'd0;
      r_shift      <= 8'h00;
      r_par_err    <= 1'b0;
      o_rx_data    <= 8'h00;
      o_rx_valid   <= 1'b0;
      o_frame_err  <= 1'b0;
      o_parity_err <= 1'b0;
    end else begin
      r_state      <= state_nxt;
      r_baud_cnt   <= cnt_nxt;
      r_bit_idx    <= idx_nxt;
      r_shift      <= shift_nxt;
      r_par_err    <= par_err_nxt;
      o_rx_data    <= data_nxt;
      o_rx_valid   <= valid_nxt;
      o_frame_err  <= frame_nxt;
      o_parity_err <= parity_nxt;
    end
  end

endmodule

// File: tb/tb_uart_rx_drive.sv
// Scoreboard bench for uart_rx_drive: three instances (no/odd/even parity) at 16 clocks per bit.
module tb_uart_rx_drive;

  localparam int CLK_F = 16;
  localparam int BAUD  = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;
  logic [7:0] d0, d1, d2;
  logic v0, v1, v2, fe0, fe1, fe2, pe0, pe1, pe2;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_drive #(.P_CLK_FREQ(CLK_F), .P_BAUD(BAUD), .P_CHECK(0)) u_none (
    .i_clk(clk), .i_rst(rst), .i_uart_rx(rx0), .o_rx_data(d0),
    .o_rx_valid(v0), .o_frame_err(fe0), .o_parity_err(pe0));
  uart_rx_drive #(.P_CLK_FREQ(CLK_F), .P_BAUD(BAUD), .P_CHECK(1)) u_odd (
    .i_clk(clk), .i_rst(rst), .i_uart_rx(rx1), .o_rx_data(d1),
    .o_rx_valid(v1), .o_frame_err(fe1), .o_parity_err(pe1));
  uart_rx_drive #(.P_CLK_FREQ(CLK_F), .P_BAUD(BAUD), .P_CHECK(2)) u_even (
    .i_clk(clk), .i_rst(rst), .i_uart_rx(rx2), .o_rx_data(d2),
    .o_rx_valid(v2), .o_frame_err(fe2), .o_parity_err(pe2));

  // kind: 0 = valid, 1 = frame error, 2 = parity error
  typedef struct {
    int         kind;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int id, input int kind, input logic [7:0] data, input int ecyc);
    exp_t e;
    e.kind = kind;
    e.data = data;
    e.cyc  = ecyc;
    case (id)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic setline(input int id, input logic v);
    case (id)
      0: rx0 = v;
      1: rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  // Called at a negedge, returns at a negedge; strobe expected 155 (+16 with parity) cycles on
  task automatic send(input int id, input logic [7:0] d, input int kind, input bit has_par,
                      input logic par, input logic stop, input int low_hold);
    int launch;
    launch = cyc;
    if (kind >= 0) push(id, kind, d, launch + 155 + (has_par ? 16 : 0));
    setline(id, 1'b0);
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      setline(id, d[i]);
      repeat (16) @(negedge clk);
    end
    if (has_par) begin
      setline(id, par);
      repeat (16) @(negedge clk);
    end
    setline(id, stop);
    repeat (16) @(negedge clk);
    if (!stop) begin
      repeat (low_hold) @(negedge clk);
      setline(id, 1'b1);
    end
  endtask

  task automatic mon(input int id, input logic v, input logic fe, input logic pe,
                     input logic [7:0] d);
    exp_t e;
    bit   have;
    int   kind;
    have = 1'b0;
    if (!(v || fe || pe)) return;
    chk($sformatf("dut%0d_single_strobe", id), int'(v) + int'(fe) + int'(pe), 1);
    kind = v ? 0 : (fe ? 1 : 2);
    case (id)
      0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      n_checks++;
      n_fail++;
      $display("FAIL dut%0d_unexpected_strobe: got kind %0d data 0x%02h at cycle %0d, required no strobe",
               id, kind, d, cyc);
      return;
    end
    chk($sformatf("dut%0d_kind", id), kind, e.kind);
    chk($sformatf("dut%0d_cycle", id), cyc, e.cyc);
    if (e.kind == 0) chk($sformatf("dut%0d_data", id), d, e.data);
  endtask

  always @(negedge clk) begin
    mon(0, v0, fe0, pe0, d0);
    mon(1, v1, fe1, pe1, d1);
    mon(2, v2, fe2, pe2, d2);
  end

  initial begin
    logic [7:0] partial;
    partial = 8'hC6;
    repeat (3) @(negedge clk);
    chk("rst_d0", d0, 0);  chk("rst_v0", v0, 0);  chk("rst_fe0", fe0, 0);  chk("rst_pe0", pe0, 0);
    chk("rst_d1", d1, 0);  chk("rst_v1", v1, 0);  chk("rst_fe1", fe1, 0);  chk("rst_pe1", pe1, 0);
    chk("rst_d2", d2, 0);  chk("rst_v2", v2, 0);  chk("rst_fe2", fe2, 0);  chk("rst_pe2", pe2, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // back-to-back frames, no parity
    send(0, 8'h55, 0, 1'b0, 1'b0, 1'b1, 0);
    send(0, 8'hA3, 0, 1'b0, 1'b0, 1'b1, 0);
    repeat (20) @(negedge clk);

    // even parity: 0x0F has four ones, so the correct parity bit is 0
    send(2, 8'h0F, 0, 1'b1, 1'b0, 1'b1, 0);
    repeat (20) @(negedge clk);
    send(2, 8'h0F, 2, 1'b1, 1'b1, 1'b1, 0);
    repeat (20) @(negedge clk);
    chk("dut2_data_hold_after_parity_err", d2, 8'h0F);

    // odd parity: 0x01 has one 1, so the correct parity bit is 0
    send(1, 8'h01, 0, 1'b1, 1'b0, 1'b1, 0);
    repeat (20) @(negedge clk);
    send(1, 8'h01, 2, 1'b1, 1'b1, 1'b1, 0);
    repeat (20) @(negedge clk);
    chk("dut1_data_hold_after_parity_err", d1, 8'h01);

    // short glitch rejected, then a normal frame
    setline(0, 1'b0);
    repeat (4) @(negedge clk);
    setline(0, 1'b1);
    repeat (12) @(negedge clk);
    send(0, 8'h3C, 0, 1'b0, 1'b0, 1'b1, 0);
    repeat (20) @(negedge clk);

    // stop bit low, line held low, then recovery
    send(0, 8'h81, 1, 1'b0, 1'b0, 1'b0, 40);
    repeat (20) @(negedge clk);
    send(0, 8'h7E, 0, 1'b0, 1'b0, 1'b1, 0);
    repeat (20) @(negedge clk);
    chk("dut0_data_before_reset", d0, 8'h7E);

    // reset in the middle of data bit 4
    setline(0, 1'b0);
    repeat (16) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      setline(0, partial[i]);
      repeat (16) @(negedge clk);
    end
    setline(0, partial[4]);
    repeat (8) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_d0", d0, 0);
    chk("midrst_v0", v0, 0);
    chk("midrst_fe0", fe0, 0);
    chk("midrst_pe0", pe0, 0);
    setline(0, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    send(0, 8'hC6, 0, 1'b0, 1'b0, 1'b1, 0);
    repeat (20) @(negedge clk);

    for (int i = 0; i < 400 && (q0.size() + q1.size() + q2.size()) > 0; i++) @(negedge clk);
    chk("dut0_pending_expectations", q0.size(), 0);
    chk("dut1_pending_expectations", q1.size(), 0);
    chk("dut2_pending_expectations", q2.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
